ex_hazard_controller: RTL and testbench
=======================================

Name: ex_hazard_controller

Overview:
- Sequences the EX stage of the 5-stage MIPS pipeline.
- Tracks destination registers of the instructions in EX, MEM and WB, and generates registered forwarding selects for the EX operand muxes.
- Detects load-use hazards, stalls IF/ID and injects bubbles.
- Sequences the flush window after a taken branch.
- Sits between the decode stage and the execution unit.

Parameters:
- NB_ADDR, 5, register-file index width.
- NB_FWD_SEL, 2, forwarding-select width.
- FLUSH_CYCLES, 2, number of cycles o_flush stays high per taken branch (1..7).

Ports:
- i_clock  in  1  system clock, all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_id_valid  in  1  decode stage holds a real instruction.
- i_id_rs  in  NB_ADDR  rs index of the ID instruction.
- i_id_rt  in  NB_ADDR  rt index of the ID instruction.
- i_id_uses_rs  in  1  ID instruction reads rs.
- i_id_uses_rt  in  1  ID instruction reads rt.
- i_id_dest  in  NB_ADDR  destination register of the ID instruction.
- i_id_reg_write  in  1  ID instruction writes the register file.
- i_id_mem_read  in  1  ID instruction is a load.
- i_ex_branch_taken  in  1  the instruction in EX is a branch resolved taken.
- o_fwd_rs_sel  out  NB_FWD_SEL  EX first-operand source: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- o_fwd_rt_sel  out  NB_FWD_SEL  same encoding for the second operand.
- o_stall  out  1  hold PC and IF/ID this cycle.
- o_flush  out  1  kill IF/ID contents this cycle.
- o_ex_valid  out  1  the instruction now in EX is real (not a bubble).

Behaviour:
- Internal trackers ex_/mem_/wb_, each holding {valid, dest, reg_write, mem_read}. Every cycle mem<=ex and wb<=mem. ex loads the ID fields when accept=1, otherwise a bubble (all fields 0).
- accept = i_id_valid & ~o_stall & ~o_flush.
- match(src, stg) = stg.valid & stg.reg_write & (stg.dest != 0) & (src == stg.dest), gated by i_id_uses_rs or i_id_uses_rt respectively.
- Load-use: o_stall = state==RUN & ex.mem_read & (match(rs, ex) | match(rt, ex)) & i_id_valid. Combinational, and lasts exactly one cycle because the load advances to MEM and the re-evaluated select becomes 10.
- Forwarding select per operand, computed for the ID instruction: match with ex -> 01 (priority); else match with mem -> 10; else 00. Registered into o_fwd_*_sel on the same edge that loads ex. On bubble insertion both selects are 00. Register 0 is never forwarded.
- o_ex_valid = ex.valid.
- FSM states:
  - RUN: o_flush = i_ex_branch_taken & ex.valid (combinational). If asserted and FLUSH_CYCLES>1, load flush_cnt = FLUSH_CYCLES-1 and go to FLUSH.
  - FLUSH: o_flush=1 and o_stall=0. Decrement flush_cnt; return to RUN when it reaches 0. i_ex_branch_taken is ignored because ex holds bubbles.
- There is no separate STALL state; a stall is one RUN cycle with o_stall=1.
- Simultaneous branch-taken and load-use: flush wins. o_stall is forced 0 and the ID instruction becomes a bubble.
- A branch already in EX is never stalled, since stalls only hold ID and earlier stages.
- Reset, including mid-stall or mid-flush: all trackers invalid, fwd selects 00, o_stall=0, o_flush=0, o_ex_valid=0, state RUN, flush_cnt=0. Reset takes effect on the next edge.

Test Plan:
- Back-to-back ALU dependency: add $3 at ID (reg_write=1, dest=3), then sub using rs=3 the next cycle -> o_fwd_rs_sel=01 when sub is in EX, o_stall never asserted.
- Distance-2 dependency: dest=5 producer, one independent instruction, then consumer rt=5 -> o_fwd_rt_sel=10. Producer and intermediate instruction both dest=5 -> select 01 (EX priority).
- Load-use: lw dest=4, then consumer rs=4 -> o_stall=1 for exactly one cycle and o_ex_valid=0 the following cycle. Consumer then enters EX with o_fwd_rs_sel=10.
- Branch taken: i_ex_branch_taken=1 with ex.valid -> o_flush high for 2 cycles (FLUSH_CYCLES=2), ID instructions during the window produce o_ex_valid=0, a pending load-use stall is suppressed, and the FSM is back in RUN on cycle 3.
- Register 0 and reset: producer dest=0 with consumer rs=0 -> select 00, no stall. Assert i_reset during FLUSH -> next cycle o_flush=0, all selects 00, o_ex_valid=0.

Source files
------------

// File: rtl/ex_hazard_controller.sv
// EX-stage hazard controller for a 5-stage MIPS pipeline: tracks EX/MEM/WB destinations,
// registers operand forwarding selects, stalls on load-use and sequences the branch flush window.
module ex_hazard_controller #(
    parameter int NB_ADDR      = 5,
    parameter int NB_FWD_SEL   = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_id_valid,
    input  logic [NB_ADDR-1:0]    i_id_rs,
    input  logic [NB_ADDR-1:0]    i_id_rt,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic [NB_ADDR-1:0]    i_id_dest,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
    input  logic                  i_ex_branch_taken,
    output logic [NB_FWD_SEL-1:0] o_fwd_rs_sel,
    output logic [NB_FWD_SEL-1:0] o_fwd_rt_sel,
    output logic                  o_stall,
    output logic                  o_flush,
    output logic                  o_ex_valid
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    localparam logic [NB_FWD_SEL-1:0] SEL_RF    = '0;
    localparam logic [NB_FWD_SEL-1:0] SEL_EXMEM = NB_FWD_SEL'(1);
    localparam logic [NB_FWD_SEL-1:0] SEL_MEMWB = NB_FWD_SEL'(2);
    localparam logic [2:0]            FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t                r_state;
    logic [2:0]            r_flush_cnt;

    logic                  r_ex_valid, r_ex_reg_write, r_ex_mem_read;
    logic [NB_ADDR-1:0]    r_ex_dest;
    logic                  r_mem_valid, r_mem_reg_write, r_mem_mem_read;
    logic [NB_ADDR-1:0]    r_mem_dest;
    logic                  r_wb_valid, r_wb_reg_write, r_wb_mem_read;
    logic [NB_ADDR-1:0]    r_wb_dest;

    logic [NB_FWD_SEL-1:0] r_fwd_rs_sel, r_fwd_rt_sel;

    logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
    logic w_load_use, w_flush, w_stall, w_accept;
    logic w_unused_wb;

    // Register 0 is hard-wired, so a write to it never produces a forwardable value.
    function automatic logic hit(input logic uses, input logic [NB_ADDR-1:0] src,
                                 input logic stg_valid, input logic stg_reg_write,
                                 input logic [NB_ADDR-1:0] stg_dest);
        return uses & stg_valid & stg_reg_write & (stg_dest != '0) & (src == stg_dest);
    endfunction

    // The younger producer (currently in EX) holds the newest value, so it wins.
    function automatic logic [NB_FWD_SEL-1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex)
            return SEL_EXMEM;
        else if (hit_mem)
            return SEL_MEMWB;
        else
            return SEL_RF;
    endfunction

    always_comb begin
        w_rs_ex    = hit(i_id_uses_rs, i_id_rs, r_ex_valid, r_ex_reg_write, r_ex_dest);
        w_rt_ex    = hit(i_id_uses_rt, i_id_rt, r_ex_valid, r_ex_reg_write, r_ex_dest);
        w_rs_mem   = hit(i_id_uses_rs, i_id_rs, r_mem_valid, r_mem_reg_write, r_mem_dest);
        w_rt_mem   = hit(i_id_uses_rt, i_id_rt, r_mem_valid, r_mem_reg_write, r_mem_dest);
        w_load_use = r_ex_mem_read & (w_rs_ex | w_rt_ex) & i_id_valid;
        w_flush    = (r_state == ST_FLUSH) |
                     ((r_state == ST_RUN) & i_ex_branch_taken & r_ex_valid);
        w_stall    = (r_state == ST_RUN) & w_load_use & ~w_flush;
        w_accept   = i_id_valid & ~w_stall & ~w_flush;
    end

    // WB tracker is kept for pipeline visibility; forwarding only needs EX and MEM.
    assign w_unused_wb = ^{r_wb_valid, r_wb_reg_write, r_wb_mem_read, r_wb_dest};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ex_valid      <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_dest       <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_mem_dest      <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_read   <= 1'b0;
            r_wb_dest       <= '0;
            r_fwd_rs_sel    <= SEL_RF;
            r_fwd_rt_sel    <= SEL_RF;
        end else begin
            r_mem_valid     <= r_ex_valid;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem_read  <= r_ex_mem_read;
            r_mem_dest      <= r_ex_dest;
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_mem_read   <= r_mem_mem_read;
            r_wb_dest       <= r_mem_dest;
            if (w_accept) begin
                r_ex_valid     <= 1'b1;
                r_ex_reg_write <= i_id_reg_write;
                r_ex_mem_read  <= i_id_mem_read;
                r_ex_dest      <= i_id_dest;
                r_fwd_rs_sel   <= fwd_sel(w_rs_ex, w_rs_mem);
                r_fwd_rt_sel   <= fwd_sel(w_rt_ex, w_rt_mem);
            end else begin
                r_ex_valid     <= 1'b0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
                r_ex_dest      <= '0;
                r_fwd_rs_sel   <= SEL_RF;
                r_fwd_rt_sel   <= SEL_RF;
            end
        end
    end

    // The first flush cycle is raised combinationally in RUN; FLUSH covers the remainder.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else if (r_state == ST_RUN) begin
            if (w_flush && (FLUSH_CYCLES > 1)) begin
                r_state     <= ST_FLUSH;
                r_flush_cnt <= FLUSH_LOAD;
            end
        end else begin
            if (r_flush_cnt <= 3'd1) begin
                r_state     <= ST_RUN;
                r_flush_cnt <= 3'd0;
            end else begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

    assign o_fwd_rs_sel = r_fwd_rs_sel;
    assign o_fwd_rt_sel = r_fwd_rt_sel;
    assign o_stall      = w_stall;
    assign o_flush      = w_flush;
    assign o_ex_valid   = r_ex_valid;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed per-cycle vector bench for ex_hazard_controller plus reset corner sequences.
module tb_ex_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, uses_rs, uses_rt, reg_write, mem_read, br_taken;
    logic [4:0] id_rs, id_rt, id_dest;
    logic [1:0] fwd_rs, fwd_rt;
    logic       stall, flush, ex_valid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       vld;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dest;
        logic       rw, mr, br;
        logic [1:0] ers, ert;
        logic       est, efl, eev;
    } vec_t;

    vec_t tbl[22];

    ex_hazard_controller #(.NB_ADDR(5), .NB_FWD_SEL(2), .FLUSH_CYCLES(2)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
        .i_id_dest(id_dest), .i_id_reg_write(reg_write), .i_id_mem_read(mem_read),
        .i_ex_branch_taken(br_taken),
        .o_fwd_rs_sel(fwd_rs), .o_fwd_rt_sel(fwd_rt),
        .o_stall(stall), .o_flush(flush), .o_ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic vld, input int rs, input int rt,
                                input logic urs, input logic urt, input int dest,
                                input logic rw, input logic mr, input logic br,
                                input int ers, input int ert,
                                input logic est, input logic efl, input logic eev);
        vec_t v;
        v.vld = vld; v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt;
        v.dest = 5'(dest); v.rw = rw; v.mr = mr; v.br = br;
        v.ers = 2'(ers); v.ert = 2'(ert); v.est = est; v.efl = efl; v.eev = eev;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; uses_rs = v.urs; uses_rt = v.urt;
        id_dest = v.dest; reg_write = v.rw; mem_read = v.mr; br_taken = v.br;
    endtask

    task automatic check_all(input string tag, input int idx, input int ers, input int ert,
                             input int est, input int efl, input int eev);
        chk({tag, ".fwd_rs"}, idx, int'(fwd_rs), ers);
        chk({tag, ".fwd_rt"}, idx, int'(fwd_rt), ert);
        chk({tag, ".stall"},  idx, int'(stall), est);
        chk({tag, ".flush"},  idx, int'(flush), efl);
        chk({tag, ".ex_valid"}, idx, int'(ex_valid), eev);
    endtask

    initial begin
        //         vld rs rt urs urt dst rw mr br  ers ert st fl ev
        tbl[0]  = mk(1,  1, 2, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1,  3, 4, 1, 1,  6, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[2]  = mk(1,  7, 8, 1, 1,  9, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[3]  = mk(1,  0, 0, 0, 0,  5, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[4]  = mk(1,  1, 2, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[5]  = mk(1, 11, 5, 1, 1, 12, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[6]  = mk(1,  0, 0, 0, 0, 13, 1, 0, 0,  0, 2, 0, 0, 1);
        tbl[7]  = mk(1,  0, 0, 0, 0, 13, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[8]  = mk(1,  0,13, 0, 1, 14, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[9]  = mk(1,  0, 0, 0, 0,  4, 1, 1, 0,  0, 1, 0, 0, 1);
        tbl[10] = mk(1,  4, 0, 1, 1, 15, 1, 0, 0,  0, 0, 1, 0, 1);
        tbl[11] = mk(1,  4, 0, 1, 1, 15, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[12] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0, 0, 1);
        tbl[13] = mk(1,  0, 0, 0, 0, 20, 1, 1, 0,  0, 0, 0, 0, 0);
        tbl[14] = mk(1, 20, 0, 1, 0, 21, 1, 0, 1,  0, 0, 0, 1, 1);
        tbl[15] = mk(1, 20, 0, 1, 0, 22, 1, 0, 1,  0, 0, 0, 1, 0);
        tbl[16] = mk(1, 20, 0, 1, 0, 23, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[17] = mk(1,  0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0, 0, 1);
        tbl[18] = mk(1,  0, 0, 1, 1, 24, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[19] = mk(1, 24,24, 0, 0, 25, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[20] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[21] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);

        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_all("vec", i, tbl[i].ers, tbl[i].ert, tbl[i].est, tbl[i].efl, tbl[i].eev);
            @(posedge clk);
            #1;
        end

        // Reset asserted in the middle of a flush window.
        drive(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(1, 3, 0, 1, 0, 7, 1, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("rstflush.flush_b", 0, int'(flush), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk(1, 3, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("rstflush.flush_in", 0, int'(flush), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_all("rstflush", 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("rstflush.run_flush", 2, int'(flush), 0);

        // Reset clears a pending forwarding select that would otherwise be 01.
        drive(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk(1, 3, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_all("rstfwd", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
